// File: rtl/riscv_pkg.sv
// Shared core definitions: data width, NOP encoding, reset PC and the
// {pc, instr} entry carried from fetch to decode.
package riscv_pkg;

    localparam int              XLEN         = 32;
    localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Word-align an address by clearing the two low bits.
    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetched {pc, instr} entries with flush.
// Flush and reset both empty it; a push in a flush cycle is dropped.
module fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    output logic [OCC_W-1:0] occ,
    output fetch_entry_t     head
);

    localparam int PTR_W = $clog2(DEPTH);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_q, rd_q;
    logic [OCC_W-1:0] occ_q;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Pointer and occupancy tracking; flush wins over push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_q  <= '0;
            rd_q  <= '0;
            occ_q <= '0;
        end else begin
            if (push) wr_q <= next_ptr(wr_q);
            if (pop)  rd_q <= next_ptr(rd_q);
            case ({push, pop})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage write; a stale write under flush is harmless since occ is cleared.
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= push_data;
    end

    assign occ  = occ_q;
    assign head = mem[rd_q];

endmodule

// File: rtl/ifetch.sv
// Instruction fetch: owns the PC, issues word addresses to a one-cycle
// synchronous instruction memory, tags returning words with their PC and
// buffers them for decode. A redirect flushes everything and restarts.
module ifetch
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_pc_o,
    input  logic [31:0] imem_instr_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        redirect_valid_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [31:0]      pc_q, inflight_pc_q, last_pc_q;
    logic             inflight_q;
    logic [OCC_W-1:0] occ;
    fetch_entry_t     head, push_data;
    logic             redir, empty, pop, push, issue;
    logic [OCC_W:0]   demand;

    // Redirect is ignored while in reset so the reset PC is what gets presented.
    assign redir     = redirect_valid_i & ~rst;
    assign imem_pc_o = redir ? align_pc(redirect_pc_i) : pc_q;

    assign empty         = (occ == '0);
    assign instr_valid_o = ~empty & ~redir;
    assign pop           = instr_valid_o & instr_ready_i;

    // Slots already claimed after this cycle's pop; issue only if one stays free.
    assign demand = {1'b0, occ} + (OCC_W+1)'(inflight_q) - (OCC_W+1)'(pop);
    assign issue  = redir | (demand < (OCC_W+1)'(DEPTH));

    // The returning word belongs to the old path when a redirect is active.
    assign push      = inflight_q & ~redir;
    assign push_data = '{pc: inflight_pc_q, instr: imem_instr_i};

    // PC, in-flight tracking and the PC shown while the buffer is empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
            last_pc_q     <= '0;
        end else begin
            inflight_q <= issue;
            if (issue) begin
                inflight_pc_q <= imem_pc_o;
                pc_q          <= imem_pc_o + 32'd4;
            end
            if (!empty) last_pc_q <= head.pc;
        end
    end

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redir),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .occ       (occ),
        .head      (head)
    );

    assign instr_o    = empty ? NOP_INSTR : head.instr;
    assign instr_pc_o = empty ? last_pc_q : head.pc;

endmodule

// File: doc/ifetch.md
# ifetch

Instruction fetch unit: the initiator side of the instruction-memory fetch interface. It owns the program counter, drives word addresses into the synchronous-read instruction memory (one-cycle read latency), and tags returning words with their PC. It buffers them for the decode stage behind a valid/ready handshake and handles PC redirects from execute. It sits between the instruction memory and decode, at the front of the core pipeline.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- DEPTH, 2, fetch buffer entries; legal values ≥ 2.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- imem_pc_o  out  32  byte address presented to instruction memory; bits [1:0] always 0.
- imem_instr_i  in  32  instruction word for the address presented in the previous cycle.
- instr_valid_o  out  1  buffer head holds a valid instruction.
- instr_ready_i  in  1  decode accepts the head this cycle.
- instr_o  out  32  instruction at buffer head.
- instr_pc_o  out  32  PC of instr_o.
- redirect_valid_i  in  1  flush and restart fetch at redirect_pc_i.
- redirect_pc_i  in  32  redirect target; bits [1:0] ignored (treated as 0).

## Operation
- State: pc_q (next fetch address), inflight (1 bit), inflight_pc, buffer of DEPTH {pc, instr} entries, occupancy count occ (0..DEPTH).
- imem_pc_o = redirect_valid_i ? {redirect_pc_i[31:2], 2'b00} : pc_q (combinational mux).
- pop = instr_valid_o & instr_ready_i.
- Issue rule (no redirect): issue = (occ + inflight - pop) < DEPTH. On issue: inflight <= 1, inflight_pc <= pc_q, pc_q <= pc_q + 4 (32-bit, wraps 0xFFFF_FFFC -> 0). No issue: inflight <= 0, pc_q held. Memory data for a cycle with no issue is ignored.
- Return: if inflight, write {inflight_pc, imem_instr_i} to the buffer tail at this edge. The issue rule guarantees no overflow.
- Push and pop in the same cycle: occ unchanged, both take effect.
- Redirect (redirect_valid_i=1):
  - buffer emptied (occ <= 0); the current inflight return is discarded.
  - instr_valid_o forced 0 that cycle, so no transfer occurs.
  - fetch issued at the aligned target: inflight <= 1, inflight_pc <= target, pc_q <= target + 4.
  - Redirect overrides the issue rule.
- Back-to-back redirects: each one cancels everything from the previous one; only the last target survives.
- Reset (rst=1 at an edge): occ <= 0, inflight <= 0, pc_q <= RESET_PC. Same behaviour mid-operation; all buffered and inflight data dropped.

## Timing
- Reset values: instr_valid_o 0, instr_o 32'h0000_0013 (NOP), instr_pc_o 0, imem_pc_o RESET_PC. Redirect is ignored while rst=1.
- First cycle after reset release (c0): imem_pc_o = RESET_PC, issue. c1: data returns, pushed. c2: instr_valid_o=1, instr_pc_o=RESET_PC.
- Address-to-valid latency: 2 cycles. Redirect in cycle t gives the target valid in t+2.
- Throughput: 1 instruction/cycle sustained while instr_ready_i=1 (DEPTH ≥ 2).
- instr_o / instr_pc_o stable while instr_valid_o=1 and instr_ready_i=0.
- When the buffer is empty, instr_o holds NOP and instr_pc_o holds its last value.

## Structure
- Shared package riscv_pkg: XLEN=32, NOP_INSTR=32'h0000_0013, RESET_PC default.
- Sub-module fetch_fifo: synchronous FIFO of {pc, instr}, DEPTH entries, with push, pop, flush, occ and head outputs.
- ifetch keeps pc_q, the inflight tracking, the issue rule and the redirect mux.

## Test plan
- Reset release, memory holding word i = 0x1000_0000+i, ready=1: valid from c2, PCs 0, 4, 8…, one per cycle, instr matches the word.
- Hold ready=0 for 5 cycles from c2: occ reaches 2, no further issue, imem_pc_o holds 0x8. Release: stream resumes at 0x8 with no gap, loss or duplicate.
- Redirect to 0x40 during streaming at cycle t: valid=0 at t and t+1; at t+2 instr_pc_o=0x40, then 0x44. Old-path words never appear.
- Redirect to 0x43: fetch address 0x40; redirects on two consecutive cycles (0x80, then 0xC0): first word is PC 0xC0.
- RESET_PC=0xFFFF_FFF8: PCs 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- rst asserted mid-stream with occ=2 and inflight=1: outputs return to reset values the next cycle; after release the stream restarts at RESET_PC.
